host_init_loader: RTL and testbench

//  Host-to-device side of the GPIO host link: software writes initial ux/uy/rho per pixel.

---
 rtl/host_init_loader.sv | 191 +++++++++++++++++++
 tb/tb_host_init_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/host_init_loader.sv
// host_init_loader
//   Host-to-device loader for the GPIO host link. Software writes initial
//   ux/uy/rho words per pixel through a toggle handshake. A COMMIT command
//   then streams all three buffers in pixel order to the lattice init port.
//   The stream starts only when the collider is not in its collision stage.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_gpio_ctrl              [DW-1]=req toggle, [DW-2:DW-3]=op, [AW-1:0]=pixel addr
//   i_gpio_data              write data for the op
//   o_gpio_ack               echoes req once the command has executed
//   o_busy                   high in any state other than IDLE
//   o_addr_err               sticky, set by a write to addr >= DEPTH
//   i_in_collision_state     collider is mid-collision
//   o_init_valid/i_init_ready  stream handshake
//   o_init_addr, o_init_ux/uy/rho, o_init_last  stream beat
//   o_init_done              one-cycle pulse after the last beat is accepted
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | executes pending write/COMMIT commands
// WAIT_SAFE | COMMIT accepted, waiting for the collider to leave collision
// STREAM    | beats 0..DEPTH-1 presented on the init port
// DONE      | one-cycle init_done pulse
module host_init_loader #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 256,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_WIDTH-1:0]    i_gpio_ctrl,
  input  logic [DATA_WIDTH-1:0]    i_gpio_data,
  output logic                     o_gpio_ack,
  output logic                     o_busy,
  output logic                     o_addr_err,
  input  logic                     i_in_collision_state,
  output logic                     o_init_valid,
  input  logic                     i_init_ready,
  output logic [ADDRESS_WIDTH-1:0] o_init_addr,
  output logic [DATA_WIDTH-1:0]    o_init_ux,
  output logic [DATA_WIDTH-1:0]    o_init_uy,
  output logic [DATA_WIDTH-1:0]    o_init_rho,
  output logic                     o_init_last,
  output logic                     o_init_done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SAFE, S_STREAM, S_DONE} state_t;

  localparam logic [1:0] OP_COMMIT = 2'b11;

  state_t r_state, w_next;

  logic                     r_req;
  logic [1:0]               r_op;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_ack;
  logic                     r_err;
  logic                     r_valid;
  logic                     r_last;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_rd_ux, r_rd_uy, r_rd_rho;

  logic [DATA_WIDTH-1:0] r_mem_ux  [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_uy  [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_rho [DEPTH];

  logic                     w_pending, w_exec, w_exec_wr, w_exec_commit;
  logic                     w_accept, w_stream_start, w_rd_en, w_addr_ok;
  logic [ADDRESS_WIDTH-1:0] w_rd_addr;
  logic                     w_busy, w_done;
  logic                     w_unused_ctrl;

  assign w_unused_ctrl = ^i_gpio_ctrl[DATA_WIDTH-4:ADDRESS_WIDTH];

  generate
    if (DEPTH < (1 << ADDRESS_WIDTH)) begin : g_addr_chk
      assign w_addr_ok = (int'(r_wr_addr) < DEPTH);
    end else begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end
  endgenerate

  assign w_pending = (r_req != r_ack);
  assign w_accept  = r_valid && i_init_ready;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_pending && r_op == OP_COMMIT) w_next = S_WAIT_SAFE;
      S_WAIT_SAFE: if (!i_in_collision_state)          w_next = S_STREAM;
      S_STREAM:    if (w_accept && r_last)             w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // output / control decode
  always_comb begin
    w_busy         = (r_state != S_IDLE);
    w_done         = (r_state == S_DONE);
    w_exec         = (r_state == S_IDLE) && w_pending;
    w_exec_wr      = w_exec && (r_op != OP_COMMIT);
    w_exec_commit  = w_exec && (r_op == OP_COMMIT);
    w_stream_start = (r_state == S_WAIT_SAFE) && !i_in_collision_state;
    w_rd_en        = 1'b0;
    w_rd_addr      = r_addr;
    // The buffer read register doubles as the beat data register, so it is
    // always loaded with the address the beat will carry after this edge.
    if (w_stream_start) begin
      w_rd_en   = 1'b1;
      w_rd_addr = '0;
    end else if (r_state == S_STREAM && !(w_accept && r_last)) begin
      w_rd_en   = 1'b1;
      w_rd_addr = w_accept ? r_addr + ADDRESS_WIDTH'(1) : r_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req     <= 1'b0;
      r_op      <= '0;
      r_wr_addr <= '0;
      r_data    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_addr    <= '0;
      r_rd_ux   <= '0;
      r_rd_uy   <= '0;
      r_rd_rho  <= '0;
    end else begin
      r_req     <= i_gpio_ctrl[DATA_WIDTH-1];
      r_op      <= i_gpio_ctrl[DATA_WIDTH-2 -: 2];
      r_wr_addr <= i_gpio_ctrl[ADDRESS_WIDTH-1:0];
      r_data    <= i_gpio_data;
      if (w_exec) r_ack <= r_req;
      if (w_exec_wr && !w_addr_ok) r_err <= 1'b1;
      if (w_stream_start) begin
        r_valid <= 1'b1;
        r_addr  <= '0;
        r_last  <= (DEPTH == 1);
      end else if (r_state == S_STREAM && w_accept) begin
        if (r_last) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_addr <= r_addr + ADDRESS_WIDTH'(1);
          r_last <= (r_addr == ADDRESS_WIDTH'(DEPTH - 2));
        end
      end
      if (w_rd_en) begin
        r_rd_ux  <= r_mem_ux[w_rd_addr];
        r_rd_uy  <= r_mem_uy[w_rd_addr];
        r_rd_rho <= r_mem_rho[w_rd_addr];
      end
    end
  end

  // buffers survive reset
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_exec_wr && w_addr_ok) begin
      case (r_op)
        2'b00:   r_mem_ux[r_wr_addr]  <= r_data;
        2'b01:   r_mem_uy[r_wr_addr]  <= r_data;
        default: r_mem_rho[r_wr_addr] <= r_data;
      endcase
    end
  end

  assign o_gpio_ack   = r_ack;
  assign o_busy       = w_busy;
  assign o_addr_err   = r_err;
  assign o_init_valid = r_valid;
  assign o_init_addr  = r_addr;
  assign o_init_ux    = r_rd_ux;
  assign o_init_uy    = r_rd_uy;
  assign o_init_rho   = r_rd_rho;
  assign o_init_last  = r_last;
  assign o_init_done  = w_done;

endmodule

// File: tb/tb_host_init_loader.sv
module tb_host_init_loader;
  localparam int DW = 16;
  localparam int N  = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] gpio_ctrl, gpio_data;
  logic          gpio_ack, busy, addr_err, coll;
  logic          init_valid, init_ready, init_last, init_done;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_ux, init_uy, init_rho;

  host_init_loader #(.DATA_WIDTH(DW), .DEPTH(N), .ADDRESS_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_gpio_ctrl(gpio_ctrl), .i_gpio_data(gpio_data),
    .o_gpio_ack(gpio_ack), .o_busy(busy), .o_addr_err(addr_err),
    .i_in_collision_state(coll), .o_init_valid(init_valid), .i_init_ready(init_ready),
    .o_init_addr(init_addr), .o_init_ux(init_ux), .o_init_uy(init_uy),
    .o_init_rho(init_rho), .o_init_last(init_last), .o_init_done(init_done));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic req_state = 1'b0;
  logic [DW-1:0] m_ux [N];
  logic [DW-1:0] m_uy [N];
  logic [DW-1:0] m_rho[N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] c;
    req_state = ~req_state;
    c = '0;
    c[DW-1] = req_state;
    c[DW-2 -: 2] = op;
    c[AW-1:0] = a;
    gpio_ctrl = c;
    gpio_data = d;
  endtask

  // issue a command from IDLE and require the ack within 3 clk
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive_cmd(op, a, d);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gpio_ack === req_state) break;
    end
    check("ack_latency", 64'(gpio_ack), 64'(req_state));
    if (op == 2'b00) m_ux[a] = d;
    else if (op == 2'b01) m_uy[a] = d;
    else if (op == 2'b10) m_rho[a] = d;
  endtask

  // mode 0: ready high (except optional stall); mode 1: random ready and collision
  task automatic do_stream(input int mode, input int stall_at, input int wr_at,
                           input int rst_at, input int coll_cycles);
    int e, cyc, stalls;
    logic seen, accepted, wr_sent, ack_hold;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    e = 0; cyc = 0; stalls = 0; wr_sent = 0; ack_hold = 0;
    wa = 8'd200; wd = DW'($urandom);
    init_ready = 1'b0;
    coll = (coll_cycles > 0);
    send_cmd(2'b11, '0, '0);
    for (int i = 0; i < coll_cycles; i++) begin
      tick();
      check("wait_safe_hold", {62'd0, busy, init_valid}, 64'b10);
    end
    coll = 1'b0;
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      if (init_valid === 1'b1) seen = 1;
      else tick();
    end
    if (!seen && init_valid === 1'b1) seen = 1;
    check("first_beat_latency", 64'(seen), 64'd1);
    if (!seen) return;
    while (e < N && cyc < 5000) begin
      if (rst_at >= 0 && e == rst_at) begin
        rst = 1'b1;
        req_state = 1'b0;
        gpio_ctrl = '0;
        init_ready = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_outputs", {init_valid, busy, init_done, init_last, init_addr, gpio_ack}, 64'd0);
        for (int i = 0; i < 5; i++) begin
          tick();
          check("no_done_after_rst", {62'd0, init_done, busy}, 64'd0);
        end
        return;
      end
      if (mode == 0) check("no_bubble", 64'(init_valid), 64'd1);
      if (init_valid === 1'b1)
        check($sformatf("beat_%0d", e),
              {7'd0, init_addr, init_ux, init_uy, init_rho, init_last},
              {7'd0, AW'(e), m_ux[e], m_uy[e], m_rho[e], (e == N-1)});
      if (wr_at == e && !wr_sent) begin
        ack_hold = gpio_ack;
        drive_cmd(2'b00, wa, wd);
        wr_sent = 1;
      end else if (wr_sent) begin
        check("ack_held_in_stream", 64'(gpio_ack), 64'(ack_hold));
      end
      if (mode == 0) begin
        init_ready = 1'b1;
        if (e == stall_at && stalls < 4) begin
          init_ready = 1'b0;
          stalls++;
        end
      end else begin
        init_ready = ($urandom_range(0, 3) != 0);
        coll = $urandom_range(0, 1);
      end
      accepted = init_valid && init_ready;
      tick();
      cyc++;
      if (accepted) e++;
    end
    coll = 1'b0;
    init_ready = 1'b0;
    check("stream_complete", 64'(e), 64'(N));
    check("done_pulse", {61'd0, init_done, init_valid, busy}, 64'b101);
    tick();
    check("done_one_cycle", {62'd0, init_done, busy}, 64'd0);
    if (wr_sent) begin
      for (int i = 0; i < 3; i++) begin
        if (gpio_ack === req_state) break;
        tick();
      end
      check("deferred_write_ack", 64'(gpio_ack), 64'(req_state));
      m_ux[wa] = wd;
    end
  endtask

  initial begin
    rst = 1'b1; gpio_ctrl = '0; gpio_data = '0; coll = 1'b0; init_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_state",
          {gpio_ack, busy, addr_err, init_valid, init_last, init_done, init_addr, init_ux, init_uy, init_rho},
          64'd0);
    // fill every buffer entry with random data, then random overwrites
    for (int a = 0; a < N; a++) begin
      send_cmd(2'b00, AW'(a), DW'($urandom));
      send_cmd(2'b01, AW'(a), DW'($urandom));
      send_cmd(2'b10, AW'(a), DW'($urandom));
    end
    for (int i = 0; i < 60; i++)
      send_cmd(2'($urandom_range(0, 2)), AW'($urandom_range(0, N-1)), DW'($urandom));
    send_cmd(2'b00, 8'd5, 16'h1234);
    send_cmd(2'b01, 8'd5, 16'h0042);
    check("addr_err_clear", 64'(addr_err), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);

    do_stream(0, -1, -1, -1, 0);     // full-rate stream
    do_stream(0, 10, -1, -1, 0);     // 4-cycle stall at addr 10
    do_stream(0, -1, -1, -1, 20);    // collision holds off the stream
    do_stream(1, -1, 50, -1, 0);     // random backpressure, write during stream
    do_stream(0, -1, -1, 100, 0);    // reset mid-stream
    do_stream(0, -1, -1, -1, 0);     // restart from addr 0 with old data
    check("addr_err_final", 64'(addr_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
